// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// memory_arbiter
//   Shares one memory command port between fetch (I) and memory stage (D);
//   tracks the single outstanding read to steer its data-valid back.
//   Optional: `MEM_ARB_ROUND_ROBIN_EN` enables round-robin on collisions.
// Revision: 1.0 - initial release
// ============================================================================
module memory_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_cmd_start,
  input  logic        i_cmd_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_wmask,
  output logic        i_cmd_ready,
  output logic [31:0] i_rdata,
  output logic        i_rdata_valid,

  input  logic        d_cmd_start,
  input  logic        d_cmd_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [31:0] d_wmask,
  output logic        d_cmd_ready,
  output logic [31:0] d_rdata,
  output logic        d_rdata_valid,

  output logic        mem_cmd_start,
  output logic        mem_cmd_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_wmask,
  input  logic        mem_cmd_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,

  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT_I = 2'd1,
    ST_WAIT_D = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_e;

  state_e state_q;
  grant_e w_grant;
  logic   w_accept;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Last requester granted: 1 = D, 0 = I.
  logic   last_d_q;
`endif

  always_comb begin
    w_grant = GNT_NONE;
    if (state_q == ST_IDLE) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (d_cmd_start && i_cmd_start) begin
        w_grant = last_d_q ? GNT_I : GNT_D;
      end else if (d_cmd_start) begin
        w_grant = GNT_D;
      end else if (i_cmd_start) begin
        w_grant = GNT_I;
      end
`else
      if (d_cmd_start) begin
        w_grant = GNT_D;
      end else if (i_cmd_start) begin
        w_grant = GNT_I;
      end
`endif
    end
  end

  always_comb begin
    mem_cmd_start = 1'b0;
    mem_cmd_write = 1'b0;
    mem_addr      = 32'hffff_ffff;
    mem_wdata     = 32'hffff_ffff;
    mem_wmask     = 32'hffff_ffff;
    case (w_grant)
      GNT_I: begin
        mem_cmd_start = i_cmd_start;
        mem_cmd_write = i_cmd_write;
        mem_addr      = i_addr;
        mem_wdata     = i_wdata;
        mem_wmask     = i_wmask;
      end
      GNT_D: begin
        mem_cmd_start = d_cmd_start;
        mem_cmd_write = d_cmd_write;
        mem_addr      = d_addr;
        mem_wdata     = d_wdata;
        mem_wmask     = d_wmask;
      end
      default: begin
        mem_cmd_start = 1'b0;
      end
    endcase
  end

  assign i_cmd_ready   = (w_grant == GNT_I) && mem_cmd_ready;
  assign d_cmd_ready   = (w_grant == GNT_D) && mem_cmd_ready;
  assign w_accept      = mem_cmd_start && mem_cmd_ready;

  // Data is broadcast; only the valids are steered to the read's owner.
  assign i_rdata       = mem_rdata;
  assign d_rdata       = mem_rdata;
  assign i_rdata_valid = (state_q == ST_WAIT_I) && mem_rdata_valid;
  assign d_rdata_valid = (state_q == ST_WAIT_D) && mem_rdata_valid;
  assign busy          = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_d_q <= 1'b0;
`endif
    end else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (w_accept) begin
        last_d_q <= (w_grant == GNT_D);
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (w_accept && !mem_cmd_write) begin
            state_q <= (w_grant == GNT_D) ? ST_WAIT_D : ST_WAIT_I;
          end
        end
        ST_WAIT_I, ST_WAIT_D: begin
          if (mem_rdata_valid) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_memory_arbiter
//   Self-checking bench: expected read returns are queued at issue time and
//   popped when the arbiter steers a data-valid back.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_cmd_start, i_cmd_write;
  logic [31:0] i_addr, i_wdata, i_wmask;
  logic        i_cmd_ready, i_rdata_valid;
  logic [31:0] i_rdata;
  logic        d_cmd_start, d_cmd_write;
  logic [31:0] d_addr, d_wdata, d_wmask;
  logic        d_cmd_ready, d_rdata_valid;
  logic [31:0] d_rdata;
  logic        mem_cmd_start, mem_cmd_write;
  logic [31:0] mem_addr, mem_wdata, mem_wmask;
  logic        mem_cmd_ready, mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        busy;

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   last_d = 1'b0;

  memory_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd_start(i_cmd_start), .i_cmd_write(i_cmd_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_wmask(i_wmask), .i_cmd_ready(i_cmd_ready),
    .i_rdata(i_rdata), .i_rdata_valid(i_rdata_valid),
    .d_cmd_start(d_cmd_start), .d_cmd_write(d_cmd_write), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_cmd_ready(d_cmd_ready),
    .d_rdata(d_rdata), .d_rdata_valid(d_rdata_valid),
    .mem_cmd_start(mem_cmd_start), .mem_cmd_write(mem_cmd_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_cmd_ready(mem_cmd_ready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference grant decision for a cycle in which the arbiter is idle.
  function automatic bit pick_d(input bit i_req, input bit d_req);
    if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return d_req;
  endfunction

  task automatic clear_reqs();
    i_cmd_start = 1'b0; i_cmd_write = 1'b0;
    d_cmd_start = 1'b0; d_cmd_write = 1'b0;
  endtask

  // Memory model: returns the front expected word, then the bench checks steering.
  task automatic mem_return();
    rsp_t r;
    @(negedge clk);
    mem_rdata_valid = 1'b1;
    mem_rdata       = (exp_q.size() != 0) ? exp_q[0].data : 32'h0bad_0bad;
    #1;
    if (i_rdata_valid || d_rdata_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        chk("rv_i", i_rdata_valid, !r.is_d);
        chk("rv_d", d_rdata_valid, r.is_d);
        chk("rdata", r.is_d ? d_rdata : i_rdata, r.data);
      end
    end else begin
      chk("sb_missing_valid", 32'd0, 32'd1);
    end
    chk("ret_no_fwd", mem_cmd_start, 1'b0);
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    #1;
    chk("busy_after_ret", busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit w;
    rst_n = 1'b0;
    clear_reqs();
    i_addr = '0; i_wdata = '0; i_wmask = '0;
    d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b0; mem_rdata = 32'h1234_5678;
    #2;
    chk("rst_busy", busy, 1'b0);
    chk("rst_start", mem_cmd_start, 1'b0);
    chk("rst_write", mem_cmd_write, 1'b0);
    chk("rst_addr", mem_addr, 32'hffff_ffff);
    chk("rst_wdata", mem_wdata, 32'hffff_ffff);
    chk("rst_wmask", mem_wmask, 32'hffff_ffff);
    chk("rst_rdy", {i_cmd_ready, d_cmd_ready, i_rdata_valid, d_rdata_valid}, 4'd0);
    chk("rst_rdata_i", i_rdata, 32'h1234_5678);
    chk("rst_rdata_d", d_rdata, 32'h1234_5678);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single fetch read.
    @(negedge clk);
    i_cmd_start = 1'b1; i_addr = 32'h100; mem_cmd_ready = 1'b1;
    #1;
    w = pick_d(1'b1, 1'b0);
    chk("f_addr", mem_addr, 32'h100);
    chk("f_start", mem_cmd_start, 1'b1);
    chk("f_ready", i_cmd_ready, 1'b1);
    chk("f_dready", d_cmd_ready, 1'b0);
    exp_q.push_back('{is_d: 1'b0, data: 32'hdead_beef});
    last_d = w;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      clear_reqs();
      #1;
      chk("f_busy", busy, 1'b1);
    end
    mem_return();

    // Data write: forwarded unchanged, no outstanding state.
    @(negedge clk);
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'h2000;
    d_wdata = 32'h55; d_wmask = 32'h0000_00ff;
    #1;
    chk("w_ready", d_cmd_ready, 1'b1);
    chk("w_write", mem_cmd_write, 1'b1);
    chk("w_addr", mem_addr, 32'h2000);
    chk("w_wdata", mem_wdata, 32'h55);
    chk("w_wmask", mem_wmask, 32'h0000_00ff);
    last_d = 1'b1;
    @(negedge clk);
    clear_reqs();
    #1;
    chk("w_busy", busy, 1'b0);

    // Collision: winner read, loser held and blocked until after the return.
    @(negedge clk);
    i_cmd_start = 1'b1; i_addr = 32'h300;
    d_cmd_start = 1'b1; d_addr = 32'h400;
    #1;
    w = pick_d(1'b1, 1'b1);
    chk("c_dready", d_cmd_ready, w);
    chk("c_iready", i_cmd_ready, !w);
    chk("c_addr", mem_addr, w ? 32'h400 : 32'h300);
    exp_q.push_back('{is_d: w, data: 32'ha5a5_0400});
    last_d = w;
    @(negedge clk);
    if (w) d_cmd_start = 1'b0; else i_cmd_start = 1'b0;
    #1;
    chk("c_block_start", mem_cmd_start, 1'b0);
    chk("c_block_rdy", {i_cmd_ready, d_cmd_ready}, 2'b00);
    chk("c_block_busy", busy, 1'b1);
    mem_return();
    #1;
    chk("c_loser_ready", w ? i_cmd_ready : d_cmd_ready, 1'b1);
    chk("c_loser_addr", mem_addr, w ? 32'h300 : 32'h400);
    exp_q.push_back('{is_d: !w, data: 32'h5a5a_0300});
    last_d = !w;
    @(negedge clk);
    clear_reqs();
    mem_return();

    // Stray valid while idle.
    @(negedge clk);
    mem_rdata_valid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("stray_valid", {i_rdata_valid, d_rdata_valid}, 2'b00);
    chk("stray_busy", busy, 1'b0);
    @(negedge clk);
    mem_rdata_valid = 1'b0;

    // Start without ready, then dropped: nothing accepted.
    mem_cmd_ready = 1'b0; i_cmd_start = 1'b1; i_addr = 32'h500;
    #1;
    chk("nr_start", mem_cmd_start, 1'b1);
    chk("nr_ready", i_cmd_ready, 1'b0);
    @(negedge clk);
    clear_reqs(); mem_cmd_ready = 1'b1;
    #1;
    chk("nr_drop", mem_cmd_start, 1'b0);
    chk("nr_busy", busy, 1'b0);

    // Both held with writes: grant sequence per arbitration policy.
    @(negedge clk);
    i_cmd_start = 1'b1; i_cmd_write = 1'b1; i_addr = 32'ha0;
    d_cmd_start = 1'b1; d_cmd_write = 1'b1; d_addr = 32'hb0;
    for (int k = 0; k < 4; k++) begin
      #1;
      w = pick_d(1'b1, 1'b1);
      chk("rr_dready", d_cmd_ready, w);
      chk("rr_iready", i_cmd_ready, !w);
      chk("rr_addr", mem_addr, w ? 32'hb0 : 32'ha0);
      last_d = w;
      @(negedge clk);
    end
    clear_reqs();

    // Reset pulsed while a fetch read is outstanding.
    i_cmd_start = 1'b1; i_addr = 32'h700;
    #1;
    chk("rm_ready", i_cmd_ready, 1'b1);
    @(negedge clk);
    clear_reqs();
    #1;
    chk("rm_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rm_busy_rst", busy, 1'b0);
    rst_n = 1'b1;
    last_d = 1'b0;
    @(negedge clk);
    mem_rdata_valid = 1'b1; mem_rdata = 32'hcafe_f00d;
    #1;
    chk("rm_valid", {i_rdata_valid, d_rdata_valid}, 2'b00);
    chk("rm_idle", busy, 1'b0);
    @(negedge clk);
    mem_rdata_valid = 1'b0;
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
